// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one op at a time to the ALU, holds operands while the ALU is busy, and buffers the result for writeback
//   I_clk, I_reset_n                   clock, asynchronous active-low reset
//   I_valid/O_ready, I_aluop, I_src1,
//   I_src2, I_tag, I_kill              op intake from decode, plus pipeline flush
//   O_alu_en/op/s1/s2                  ALU drive, held stable from accept to completion
//   I_alu_busy/data/lt/ltu/eq          ALU status and result
//   O_valid/I_ready, O_data, O_tag,
//   O_lt, O_ltu, O_eq                  result handshake to writeback
//   O_stall_cnt, O_timeout             saturating busy-cycle count, sticky long-wait flag
module alu_sequencer #(
  parameter int TAG_W    = 5,
  parameter int MAX_WAIT = 48
) (
  input  logic             I_clk,
  input  logic             I_reset_n,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [4:0]       I_aluop,
  input  logic [31:0]      I_src1,
  input  logic [31:0]      I_src2,
  input  logic [TAG_W-1:0] I_tag,
  input  logic             I_kill,
  output logic             O_alu_en,
  output logic [4:0]       O_alu_op,
  output logic [31:0]      O_alu_s1,
  output logic [31:0]      O_alu_s2,
  input  logic             I_alu_busy,
  input  logic [31:0]      I_alu_data,
  input  logic             I_alu_lt,
  input  logic             I_alu_ltu,
  input  logic             I_alu_eq,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [31:0]      O_data,
  output logic [TAG_W-1:0] O_tag,
  output logic             O_lt,
  output logic             O_ltu,
  output logic             O_eq,
  output logic [15:0]      O_stall_cnt,
  output logic             O_timeout
);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;
  state_t           state, state_nx;
  logic [TAG_W-1:0] tag_h;
  logic [15:0]      wait_cnt;
  logic             drop, accept, silent, in_flight;
  assign O_alu_en  = state == EXEC;
  assign O_valid   = state == DONE;
  assign in_flight = state == EXEC || state == WAIT;
  // a kill arriving in the completion cycle itself still suppresses the result
  assign silent    = drop || I_kill;
  always_comb begin
    O_ready  = I_reset_n && !I_kill && (state == IDLE || (state == DONE && I_ready));
    accept   = I_valid && O_ready;
    state_nx = state == IDLE ? (accept ? EXEC : IDLE) :
               state == EXEC ? WAIT :
               state == WAIT ? (I_alu_busy ? WAIT : (silent ? IDLE : DONE)) :
               accept ? EXEC : ((I_ready || I_kill) ? IDLE : DONE);
  end
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state       <= IDLE;
      O_alu_op    <= '0;
      O_alu_s1    <= '0;
      O_alu_s2    <= '0;
      tag_h       <= '0;
      wait_cnt    <= '0;
      drop        <= 1'b0;
      O_data      <= '0;
      O_tag       <= '0;
      O_lt        <= 1'b0;
      O_ltu       <= 1'b0;
      O_eq        <= 1'b0;
      O_stall_cnt <= '0;
      O_timeout   <= 1'b0;
    end else begin
      state <= state_nx;
      drop  <= state_nx == IDLE ? 1'b0 : drop || (I_kill && in_flight);
      if (accept) begin
        O_alu_op <= I_aluop;
        O_alu_s1 <= I_src1;
        O_alu_s2 <= I_src2;
        tag_h    <= I_tag;
        wait_cnt <= '0;
      end
      if (state == WAIT && I_alu_busy) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 16'd1;
        if (O_stall_cnt != '1) O_stall_cnt <= O_stall_cnt + 16'd1;
        if (wait_cnt >= 16'(MAX_WAIT)) O_timeout <= 1'b1;
      end
      if (state == WAIT && !I_alu_busy && !silent) begin
        O_data <= I_alu_data;
        O_tag  <= tag_h;
        O_lt   <= I_alu_lt;
        O_ltu  <= I_alu_ltu;
        O_eq   <= I_alu_eq;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector bench for alu_sequencer with a stand-in variable-latency ALU
module tb_alu_sequencer;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_MUL = 5'd3, OP_DIV = 5'd4, OP_DIVU = 5'd5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid = 1'b0, ready_up, kill = 1'b0, wb_ready = 1'b1;
  logic [4:0] aluop = '0, alu_op, tag = '0, o_tag;
  logic [31:0] src1 = '0, src2 = '0, alu_s1, alu_s2, alu_data, o_data;
  logic alu_en, alu_busy, alu_lt, alu_ltu, alu_eq, o_valid, o_lt, o_ltu, o_eq, o_timeout;
  logic [15:0] o_stall;
  int n_vec = 0, n_err = 0, lat, exp_stall = 0;
  logic stable, seen, ok;
  always #5 clk = ~clk;
  alu_sequencer #(.TAG_W(5), .MAX_WAIT(16)) dut (
    .I_clk(clk), .I_reset_n(rst_n), .I_valid(valid), .O_ready(ready_up), .I_aluop(aluop),
    .I_src1(src1), .I_src2(src2), .I_tag(tag), .I_kill(kill), .O_alu_en(alu_en),
    .O_alu_op(alu_op), .O_alu_s1(alu_s1), .O_alu_s2(alu_s2), .I_alu_busy(alu_busy),
    .I_alu_data(alu_data), .I_alu_lt(alu_lt), .I_alu_ltu(alu_ltu), .I_alu_eq(alu_eq),
    .O_valid(o_valid), .I_ready(wb_ready), .O_data(o_data), .O_tag(o_tag), .O_lt(o_lt),
    .O_ltu(o_ltu), .O_eq(o_eq), .O_stall_cnt(o_stall), .O_timeout(o_timeout));
  logic [5:0] blft;
  logic signed [31:0] sq;
  assign alu_busy = blft != 6'd0;
  assign sq = $signed(alu_s1) / $signed(alu_s2);
  always @(posedge clk) begin
    if (!rst_n) blft <= '0;
    else if (alu_en) begin
      blft <= '0;
      case (alu_op)
        OP_ADD:  alu_data <= alu_s1 + alu_s2;
        OP_SUB:  alu_data <= alu_s1 - alu_s2;
        OP_SLL:  begin alu_data <= alu_s1 << alu_s2[4:0]; blft <= {1'b0, alu_s2[4:0]} + 6'd1; end
        OP_MUL:  begin alu_data <= alu_s1 * alu_s2; blft <= 6'd33; end
        OP_DIV:  if (alu_s2 == 0) alu_data <= '1; else begin alu_data <= sq; blft <= 6'd33; end
        OP_DIVU: if (alu_s2 == 0) alu_data <= '1; else begin alu_data <= alu_s1 / alu_s2; blft <= 6'd33; end
        default: alu_data <= '0;
      endcase
      alu_lt  <= $signed(alu_s1) < $signed(alu_s2);
      alu_ltu <= alu_s1 < alu_s2;
      alu_eq  <= alu_s1 == alu_s2;
    end else if (blft != 6'd0) blft <= blft - 6'd1;
  end
  typedef struct {
    logic [4:0] op; logic [31:0] a, b; logic [4:0] tag;
    logic [31:0] res; logic lt, ltu, eq; int lat, dstall;
  } vec_t;
  vec_t tv[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, b, input logic [4:0] t,
                        output int l, output logic st);
    valid = 1'b1; aluop = op; src1 = a; src2 = b; tag = t;
    #1;
    chk("accept_ready", ready_up, 1);
    step();
    valid = 1'b0; l = 1; st = 1'b1;
    while (!o_valid && l < 200) begin
      if (alu_s1 !== a || alu_s2 !== b || alu_op !== op) st = 1'b0;
      step();
      l++;
    end
  endtask
  initial begin
    tv[0] = '{OP_ADD,  32'd5,        32'd7,        5'd3,  32'd12,         1'b1, 1'b1, 1'b0, 3,  0};
    tv[1] = '{OP_SLL,  32'd1,        32'd4,        5'd1,  32'h10,         1'b1, 1'b1, 1'b0, 8,  5};
    tv[2] = '{OP_DIVU, 32'h64,       32'd0,        5'd2,  32'hFFFFFFFF,   1'b0, 1'b0, 1'b0, 3,  0};
    tv[3] = '{OP_MUL,  32'hFFFFFFFD, 32'd7,        5'd4,  32'hFFFFFFEB,   1'b1, 1'b0, 1'b0, 36, 33};
    tv[4] = '{OP_SUB,  32'd3,        32'd9,        5'd5,  32'hFFFFFFFA,   1'b1, 1'b1, 1'b0, 3,  0};
    tv[5] = '{OP_DIV,  32'hFFFFFF9C, 32'd7,        5'd6,  32'hFFFFFFF2,   1'b1, 1'b0, 1'b0, 36, 33};
    tv[6] = '{OP_SLL,  32'hFFFFFFFF, 32'd0,        5'd31, 32'hFFFFFFFF,   1'b1, 1'b0, 1'b0, 4,  1};
    tv[7] = '{OP_ADD,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,          1'b1, 1'b0, 1'b0, 3,  0};
    tv[8] = '{OP_SUB,  32'h5A,       32'h5A,       5'd8,  32'd0,          1'b0, 1'b0, 1'b1, 3,  0};
    step();
    step();
    chk("rst_ready", ready_up, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_en", alu_en, 0);
    chk("rst_stall", o_stall, 0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", ready_up, 1);
    kill = 1'b1; valid = 1'b1;
    #1;
    chk("kill_blocks_ready", ready_up, 0);
    step();
    chk("kill_blocks_accept", alu_en, 0);
    kill = 1'b0; valid = 1'b0;
    valid = 1'b1; aluop = OP_SLL; src1 = 32'd1; src2 = 32'd31; tag = 5'd7;
    step();
    valid = 1'b0; lat = 1;
    while (!o_valid && lat < 200) begin
      if (lat == 18) chk("timeout_pre", o_timeout, 0);
      if (lat == 19) chk("timeout_set", o_timeout, 1);
      step();
      lat++;
    end
    exp_stall += 32;
    chk("to_lat", lat, 35);
    chk("to_data", o_data, 32'h80000000);
    chk("to_tag", o_tag, 7);
    chk("to_stall", o_stall, exp_stall);
    for (int i = 0; i < 9; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].tag, lat, stable);
      exp_stall += tv[i].dstall;
      chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("v%0d_data", i), o_data, tv[i].res);
      chk($sformatf("v%0d_tag", i), o_tag, tv[i].tag);
      chk($sformatf("v%0d_flags", i), {o_lt, o_ltu, o_eq}, {tv[i].lt, tv[i].ltu, tv[i].eq});
      chk($sformatf("v%0d_stall", i), o_stall, exp_stall);
      chk($sformatf("v%0d_stable", i), stable, 1);
    end
    chk("timeout_sticky", o_timeout, 1);
    step();
    wb_ready = 1'b0;
    run_op(OP_SUB, 32'd9, 32'd9, 5'd9, lat, stable);
    chk("bp_lat", lat, 3);
    valid = 1'b1; aluop = OP_ADD; src1 = 32'd2; src2 = 32'd3; tag = 5'd4;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!o_valid || o_data !== 32'd0 || !o_eq || o_tag !== 5'd9 || ready_up || alu_s1 !== 32'd9) ok = 1'b0;
      step();
    end
    chk("bp_hold", ok, 1);
    wb_ready = 1'b1;
    #1;
    chk("bp_ready_on_hs", ready_up, 1);
    step();
    valid = 1'b0;
    chk("b2b_valid_drop", o_valid, 0);
    chk("b2b_exec", alu_en, 1);
    lat = 1;
    while (!o_valid && lat < 200) begin
      step();
      lat++;
    end
    chk("b2b_lat", lat, 3);
    chk("b2b_data", o_data, 32'd5);
    step();
    valid = 1'b1; aluop = OP_DIV; src1 = 32'd100; src2 = 32'd7; tag = 5'd11;
    step();
    valid = 1'b0; lat = 1; seen = 1'b0;
    while (lat < 60) begin
      kill = lat == 11;
      if (o_valid) seen = 1'b1;
      step();
      lat++;
    end
    kill = 1'b0;
    exp_stall += 33;
    chk("kill_no_valid", seen, 0);
    chk("kill_idle", ready_up, 1);
    chk("kill_stall", o_stall, exp_stall);
    run_op(OP_ADD, 32'd1, 32'd1, 5'd12, lat, stable);
    chk("post_kill_lat", lat, 3);
    chk("post_kill_data", o_data, 32'd2);
    chk("post_kill_tag", o_tag, 12);
    step();
    valid = 1'b1; aluop = OP_SLL; src1 = 32'd1; src2 = 32'd31; tag = 5'd13;
    step();
    valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    #1;
    chk("arst_en", alu_en, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_ready", ready_up, 0);
    chk("arst_data", o_data, 0);
    chk("arst_tag", o_tag, 0);
    chk("arst_flags", {o_lt, o_ltu, o_eq}, 0);
    chk("arst_stall", o_stall, 0);
    chk("arst_timeout", o_timeout, 0);
    chk("arst_hold", {alu_op, alu_s1, alu_s2}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_idle", ready_up, 1);
    chk("arst_idle_en", alu_en, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue and completion sequencer in front of the integer ALU. It accepts one operation at a time from decode over a valid/ready handshake and drives the ALU's enable, opcode and operand inputs, holding them stable for as long as the ALU reports busy. When the ALU finishes, it captures the result and the lt/ltu/eq flags and presents them to writeback over a second valid/ready handshake. It hides the ALU's variable latency (single-cycle ops, multi-cycle shift, mul and div) from the surrounding pipeline.

## Interface
- TAG_W, 5, width of the destination tag carried alongside each op
- MAX_WAIT, 48, busy-cycle limit before the timeout flag is raised
- I_clk  in  1  clock
- I_reset_n  in  1  asynchronous, active-low reset
- I_valid  in  1  upstream op valid
- O_ready  out  1  sequencer can accept an op this cycle
- I_aluop  in  5  `ALUOP_*` code from cpu/aludefs.vh
- I_src1, I_src2  in  32  operands
- I_tag  in  TAG_W  destination tag
- I_kill  in  1  pipeline flush
- O_alu_en, O_alu_op[4:0], O_alu_s1[31:0], O_alu_s2[31:0]  out  to ALU I_en/I_aluop/I_dataS1/I_dataS2
- I_alu_busy, I_alu_data[31:0], I_alu_lt, I_alu_ltu, I_alu_eq  in  from ALU
- O_valid  out  1  result valid to writeback
- I_ready  in  1  writeback accepts
- O_data  out  32  captured result
- O_tag  out  TAG_W  tag of result
- O_lt, O_ltu, O_eq  out  1  captured flags
- O_stall_cnt  out  16  saturating count of cycles with I_alu_busy high in WAIT
- O_timeout  out  1  sticky; set when a single op waits more than MAX_WAIT cycles

## Operation
- States: IDLE, EXEC, WAIT, DONE. Reset puts the block in IDLE, drives every output register to 0 and sets O_ready=0 for the reset cycle only.
- The hold registers (op, s1, s2, tag) drive O_alu_* continuously. They load only on an accept, so the operands stay stable throughout WAIT.
- IDLE: O_ready = !I_kill. An accept (I_valid && O_ready) loads the hold registers and moves to EXEC.
- EXEC: O_alu_en=1 for exactly one cycle, then WAIT.
- WAIT: O_alu_en=0.
  - If I_alu_busy=0, capture I_alu_data and the three flags into the output registers, then go to DONE and set O_valid=1. If the drop flag is set, go to IDLE instead and do not set O_valid.
  - If I_alu_busy=1, stay in WAIT and increment the wait counter and O_stall_cnt. O_stall_cnt saturates at 0xFFFF.
- DONE: O_valid is held with stable data until I_ready.
  - On handshake, O_valid falls.
  - O_ready = I_ready && !I_kill. A simultaneous accept goes straight to EXEC; otherwise the block returns to IDLE.
- Kill:
  - In DONE, O_valid clears next cycle and the block goes to IDLE.
  - In EXEC or WAIT, the ALU cannot be aborted. Set the drop flag and finish the op silently.
  - In IDLE, kill blocks the accept that cycle.
  - The drop flag clears on entry to IDLE.
- Timeout: when the wait counter exceeds MAX_WAIT, set O_timeout. It clears only on reset. The state machine keeps waiting.

## Timing
- Accept at edge 0 → EXEC in cycle 1 → first WAIT cycle in cycle 2.
- Single-cycle ops: I_alu_busy=0 in the first WAIT cycle, so O_valid rises at edge 3. Accept-to-valid latency is 3 cycles.
- Shift by n: busy is high for n+1 WAIT cycles, latency 3+n+1.
- Mul, and div with a non-zero divisor: busy is high for 33 cycles, latency 36.
- Div/rem by zero: busy never rises, latency 3.
- Max throughput: one op per 3 cycles (DONE→EXEC back-to-back).
- Async reset asserted mid-WAIT: O_alu_en=0 and O_valid=0 immediately. The ALU's own synchronous reset is asserted by the top in the same window.

## Test plan
- ADD 5+7, tag 3, I_ready=1 → O_valid exactly 3 cycles after accept, O_data=12, O_tag=3, O_lt=1, O_eq=0.
- SLL 1 by 4 → O_alu_s1/s2 stable for 5 busy cycles, O_data=0x10, latency 8, O_stall_cnt=5.
- DIVU 0x64 / 0 → O_data=0xFFFFFFFF, latency 3, O_stall_cnt unchanged; then MUL -3 × 7 → O_data=0xFFFFFFEB after 33 busy cycles.
- SUB 9-9 with I_ready low for 5 cycles → O_valid, O_data=0, O_eq=1 held unchanged; O_ready=0 until the handshake; a new op offered in the handshake cycle is accepted in that same cycle.
- I_kill in the 10th WAIT cycle of DIV → no O_valid, return to IDLE when busy drops, next ADD 1+1 gives O_data=2 normally.
- SLL by 31 with MAX_WAIT=16 → O_timeout sets after the 17th busy cycle, result 0x80000000 is still delivered. Then assert I_reset_n=0 mid-op → all outputs 0 asynchronously, state IDLE.
